// File: rtl/gate_truth_checker_if.sv
// Bundles the stimulus/check signals between the truth checker and the gate bench.
// The checker takes the master side; whoever hosts the gate takes the slave side.
interface gate_truth_checker_if #(
    parameter int ERR_W = 8
);
    logic             start;
    logic             dut_out;
    logic             in_1;
    logic             in_2;
    logic             busy;
    logic             done;
    logic             pass;
    logic [3:0]       fail_vec;
    logic [ERR_W-1:0] err_count;

    modport master (
        input  start, dut_out,
        output in_1, in_2, busy, done, pass, fail_vec, err_count
    );

    modport slave (
        output start, dut_out,
        input  in_1, in_2, busy, done, pass, fail_vec, err_count
    );
endinterface

// File: rtl/gate_truth_checker.sv
// Self-timed exhaustive stimulus and check stage for a 2-input gate.
// Each vector settles before sampling, and errors accumulate across repeated sweeps.
module gate_truth_checker #(
    parameter logic [3:0] EXPECTED_TT   = 4'b0110,
    parameter int         SETTLE_CYCLES = 2,
    parameter int         RUNS          = 1,
    parameter int         ERR_W         = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    gate_truth_checker_if.master  bus
);
    localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int RUN_W = (RUNS > 1) ? $clog2(RUNS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(RUNS - 1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_CHECK} state_t;

    state_t           state, state_nx;
    logic [1:0]       vec, vec_nx;
    logic [RUN_W-1:0] run, run_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic [1:0]       ins, ins_nx;
    logic             busy, busy_nx;
    logic             done, done_nx;
    logic             pass, pass_nx;
    logic [3:0]       fail_vec, fail_vec_nx;
    logic [ERR_W-1:0] err_count, err_count_nx;
    logic             mismatch;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            vec       <= '0;
            run       <= '0;
            cnt       <= '0;
            ins       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            fail_vec  <= '0;
            err_count <= '0;
        end else begin
            state     <= state_nx;
            vec       <= vec_nx;
            run       <= run_nx;
            cnt       <= cnt_nx;
            ins       <= ins_nx;
            busy      <= busy_nx;
            done      <= done_nx;
            pass      <= pass_nx;
            fail_vec  <= fail_vec_nx;
            err_count <= err_count_nx;
        end
    end

    // The case-equality compare makes an X or Z gate output count as a mismatch.
    always_comb begin
        state_nx     = state;
        vec_nx       = vec;
        run_nx       = run;
        cnt_nx       = cnt;
        ins_nx       = ins;
        busy_nx      = busy;
        done_nx      = 1'b0;
        pass_nx      = pass;
        fail_vec_nx  = fail_vec;
        err_count_nx = err_count;
        mismatch     = 1'b0;

        case (state)
            S_IDLE: begin
                if (bus.start) begin
                    vec_nx       = '0;
                    run_nx       = '0;
                    cnt_nx       = '0;
                    ins_nx       = 2'b00;
                    busy_nx      = 1'b1;
                    pass_nx      = 1'b0;
                    fail_vec_nx  = '0;
                    err_count_nx = '0;
                    state_nx     = S_WAIT;
                end
            end
            S_WAIT: begin
                cnt_nx = cnt + 1'b1;
                if (cnt == CNT_LAST) begin
                    state_nx = S_CHECK;
                end
            end
            S_CHECK: begin
                mismatch = (bus.dut_out !== EXPECTED_TT[vec]);
                if (mismatch) begin
                    fail_vec_nx[vec] = 1'b1;
                    if (!(&err_count)) begin
                        err_count_nx = err_count + 1'b1;
                    end
                end
                if (vec != 2'd3) begin
                    vec_nx   = vec + 1'b1;
                    ins_nx   = vec + 1'b1;
                    cnt_nx   = '0;
                    state_nx = S_WAIT;
                end else if (run != RUN_LAST) begin
                    run_nx   = run + 1'b1;
                    vec_nx   = '0;
                    ins_nx   = 2'b00;
                    cnt_nx   = '0;
                    state_nx = S_WAIT;
                end else begin
                    ins_nx   = 2'b00;
                    busy_nx  = 1'b0;
                    done_nx  = 1'b1;
                    pass_nx  = !mismatch && (err_count == '0);
                    state_nx = S_IDLE;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    assign bus.in_1      = ins[1];
    assign bus.in_2      = ins[0];
    assign bus.busy      = busy;
    assign bus.done      = done;
    assign bus.pass      = pass;
    assign bus.fail_vec  = fail_vec;
    assign bus.err_count = err_count;
endmodule

// File: tb/tb_gate_truth_checker.sv
// Scoreboard bench for gate_truth_checker: three instances cover a good/inverted XOR,
// a stuck-at-0 gate over four sweeps, and a stuck-at-1 gate with a 3-bit saturating counter.
module tb_gate_truth_checker;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    gate_truth_checker_if #(.ERR_W(8)) bus_def ();
    gate_truth_checker_if #(.ERR_W(8)) bus_r4 ();
    gate_truth_checker_if #(.ERR_W(3)) bus_sat ();

    logic inv_def;
    assign bus_def.dut_out = bus_def.in_1 ^ bus_def.in_2 ^ inv_def;
    assign bus_r4.dut_out  = 1'b0;
    assign bus_sat.dut_out = 1'b1;

    gate_truth_checker u_def (.clk(clk), .rst(rst), .bus(bus_def));
    gate_truth_checker #(.RUNS(4)) u_r4 (.clk(clk), .rst(rst), .bus(bus_r4));
    gate_truth_checker #(.RUNS(4), .ERR_W(3)) u_sat (.clk(clk), .rst(rst), .bus(bus_sat));

    typedef struct {
        int         lat;
        logic       pass;
        logic [3:0] fv;
        int         err;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_bad = 0;

    int          sel;
    logic        sel_done, sel_busy, sel_pass, sel_in1, sel_in2;
    logic [3:0]  sel_fv;
    logic [31:0] sel_err;

    always_comb begin
        sel_done = bus_def.done;
        sel_busy = bus_def.busy;
        sel_pass = bus_def.pass;
        sel_in1  = bus_def.in_1;
        sel_in2  = bus_def.in_2;
        sel_fv   = bus_def.fail_vec;
        sel_err  = 32'(bus_def.err_count);
        if (sel == 1) begin
            sel_done = bus_r4.done;
            sel_busy = bus_r4.busy;
            sel_pass = bus_r4.pass;
            sel_in1  = bus_r4.in_1;
            sel_in2  = bus_r4.in_2;
            sel_fv   = bus_r4.fail_vec;
            sel_err  = 32'(bus_r4.err_count);
        end else if (sel == 2) begin
            sel_done = bus_sat.done;
            sel_busy = bus_sat.busy;
            sel_pass = bus_sat.pass;
            sel_in1  = bus_sat.in_1;
            sel_in2  = bus_sat.in_2;
            sel_fv   = bus_sat.fail_vec;
            sel_err  = 32'(bus_sat.err_count);
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] expv);
        n_vec++;
        if (got !== expv) begin
            n_bad++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, expv);
        end
    endtask

    task automatic setStart(input int which, input logic v);
        case (which)
            0:       bus_def.start = v;
            1:       bus_r4.start  = v;
            default: bus_sat.start = v;
        endcase
    endtask

    // Starts a sweep, optionally pokes start while busy, then pops the scoreboard at done.
    task automatic applyStimulus(input int which, input exp_t e, input int poke_at, input bit chk_seq);
        exp_t got;
        int   lat;
        sel = which;
        setStart(which, 1'b1);
        exp_q.push_back(e);
        @(negedge clk);
        setStart(which, 1'b0);
        checkOutput("busy_on_accept", 32'(sel_busy), 32'd1);
        lat = 0;
        while (!sel_done && lat < 200) begin
            if (chk_seq && lat < 12)
                checkOutput("vector_order", 32'({sel_in1, sel_in2}), 32'(lat / 3));
            setStart(which, lat == poke_at);
            @(negedge clk);
            lat++;
        end
        setStart(which, 1'b0);
        got = exp_q.pop_front();
        checkOutput("done_latency", 32'(lat), 32'(got.lat));
        checkOutput("pass", 32'(sel_pass), 32'(got.pass));
        checkOutput("fail_vec", 32'(sel_fv), 32'(got.fv));
        checkOutput("err_count", sel_err, 32'(got.err));
        checkOutput("busy_at_done", 32'(sel_busy), 32'd0);
        checkOutput("inputs_at_done", 32'({sel_in1, sel_in2}), 32'd0);
        @(negedge clk);
        checkOutput("done_one_cycle", 32'(sel_done), 32'd0);
        checkOutput("pass_held", 32'(sel_pass), 32'(got.pass));
    endtask

    initial begin
        exp_t e;
        int   n_done;
        rst = 1'b1;
        inv_def = 1'b0;
        sel = 0;
        bus_def.start = 1'b1;
        bus_r4.start  = 1'b1;
        bus_sat.start = 1'b1;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            sel = i;
            #1;
            checkOutput("reset_busy", 32'(sel_busy), 32'd0);
            checkOutput("reset_done", 32'(sel_done), 32'd0);
            checkOutput("reset_pass", 32'(sel_pass), 32'd0);
            checkOutput("reset_fail_vec", 32'(sel_fv), 32'd0);
            checkOutput("reset_err", sel_err, 32'd0);
            checkOutput("reset_inputs", 32'({sel_in1, sel_in2}), 32'd0);
        end
        rst = 1'b0;
        bus_def.start = 1'b0;
        bus_r4.start  = 1'b0;
        bus_sat.start = 1'b0;
        @(negedge clk);

        e = '{12, 1'b1, 4'b0000, 0};
        applyStimulus(0, e, -1, 1'b1);

        e = '{48, 1'b0, 4'b0110, 8};
        applyStimulus(1, e, -1, 1'b0);

        inv_def = 1'b1;
        e = '{12, 1'b0, 4'b1111, 4};
        applyStimulus(0, e, -1, 1'b0);
        inv_def = 1'b0;

        e = '{12, 1'b1, 4'b0000, 0};
        applyStimulus(0, e, 5, 1'b0);

        // Abort a failing run at vector 10 and make sure no done appears afterwards.
        sel = 0;
        inv_def = 1'b1;
        setStart(0, 1'b1);
        @(negedge clk);
        setStart(0, 1'b0);
        repeat (7) @(negedge clk);
        checkOutput("abort_vector", 32'({sel_in1, sel_in2}), 32'd2);
        checkOutput("abort_err_before", sel_err, 32'd2);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        inv_def = 1'b0;
        checkOutput("abort_busy", 32'(sel_busy), 32'd0);
        checkOutput("abort_inputs", 32'({sel_in1, sel_in2}), 32'd0);
        checkOutput("abort_err", sel_err, 32'd0);
        checkOutput("abort_fail_vec", 32'(sel_fv), 32'd0);
        n_done = 0;
        for (int i = 0; i < 20; i++) begin
            if (sel_done) n_done++;
            @(negedge clk);
        end
        checkOutput("abort_no_done", 32'(n_done), 32'd0);

        e = '{12, 1'b1, 4'b0000, 0};
        applyStimulus(0, e, -1, 1'b0);

        e = '{48, 1'b0, 4'b1001, 7};
        applyStimulus(2, e, -1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
